// File: rtl/wb_forward_pipe_pkg.sv
// wb_forward_pipe_pkg: shared slot type and depth/latency constants for the writeback pipe
package wb_forward_pipe_pkg;
  localparam int DEPTH = 7;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 7;
  typedef struct packed {
    logic [0:127] data;
    logic [0:6]   addr;
    logic         write;
  } slot_t;
  function automatic logic lat_ok(input logic [2:0] lat);
    return int'(lat) >= LAT_MIN && int'(lat) <= LAT_MAX;
  endfunction
endpackage

// File: rtl/wb_forward_pipe_if.sv
// wb_forward_pipe_if: execution-unit insertion, forwarding and register-file retirement bus
interface wb_forward_pipe_if;
  import wb_forward_pipe_pkg::*;
  logic [0:127]                even_result, odd_result;
  logic [0:6]                  even_addr, odd_addr;
  logic                        even_write, odd_write;
  logic [2:0]                  even_lat, odd_lat;
  logic [DEPTH-1:0]            flush_mask;
  logic                        flush_ins;
  logic [DEPTH-1:0][0:127]     fw_even_wb, fw_odd_wb;
  logic [DEPTH-1:0][0:6]       fw_addr_even_wb, fw_addr_odd_wb;
  logic [DEPTH-1:0]            fw_write_even_wb, fw_write_odd_wb;
  logic [0:127]                rf_even_data, rf_odd_data;
  logic [0:6]                  rf_even_addr, rf_odd_addr;
  logic                        rf_even_we, rf_odd_we;
  logic                        collision_err, waw_conflict;
  modport master (
    output even_result, odd_result, even_addr, odd_addr, even_write, odd_write,
           even_lat, odd_lat, flush_mask, flush_ins,
    input  fw_even_wb, fw_odd_wb, fw_addr_even_wb, fw_addr_odd_wb, fw_write_even_wb,
           fw_write_odd_wb, rf_even_data, rf_odd_data, rf_even_addr, rf_odd_addr,
           rf_even_we, rf_odd_we, collision_err, waw_conflict
  );
  modport slave (
    input  even_result, odd_result, even_addr, odd_addr, even_write, odd_write,
           even_lat, odd_lat, flush_mask, flush_ins,
    output fw_even_wb, fw_odd_wb, fw_addr_even_wb, fw_addr_odd_wb, fw_write_even_wb,
           fw_write_odd_wb, rf_even_data, rf_odd_data, rf_even_addr, rf_odd_addr,
           rf_even_we, rf_odd_we, collision_err, waw_conflict
  );
endinterface

// File: rtl/wb_forward_pipe_lane.sv
// wb_shift_lane: one pipe's result shift register with flush masking, latency insertion and collision flag
module wb_shift_lane
  import wb_forward_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [0:127]     result_i,
  input  logic [0:6]       addr_i,
  input  logic             write_i,
  input  logic [2:0]       lat_i,
  input  logic [DEPTH-1:0] flush_mask_i,
  input  logic             flush_ins_i,
  output slot_t            slot_o [DEPTH],
  output logic             err_o
);
  slot_t slot_q [DEPTH];
  slot_t slot_d [DEPTH];
  logic  err_q, err_d, ins, coll;
  always_comb begin
    coll = 1'b0;
    ins = write_i & ~flush_ins_i & lat_ok(lat_i);
    slot_d[0] = '0;
    for (int k = 1; k < DEPTH; k++) begin
      slot_d[k] = slot_q[k-1];
      slot_d[k].write = slot_q[k-1].write & ~flush_mask_i[k-1];
    end
    // insertion overrides the shifted entry; a live victim is an error
    for (int k = 0; k < DEPTH; k++)
      if (ins && lat_i == 3'(k + 1)) begin
        coll = slot_d[k].write;
        slot_d[k] = '{data: result_i, addr: addr_i, write: 1'b1};
      end
    err_d = err_q | coll | (write_i & ~flush_ins_i & ~lat_ok(lat_i));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= '{default: '0};
      err_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      err_q <= err_d;
    end
  end
  assign slot_o = slot_q;
  assign err_o = err_q;
endmodule

// File: rtl/wb_forward_pipe.sv
// wb_forward_pipe: even/odd result shift stages with forwarding taps and WAW-arbitrated retirement
module wb_forward_pipe
  import wb_forward_pipe_pkg::*;
(
  input  logic clk,
  input  logic reset,
  wb_forward_pipe_if.slave bus
);
  slot_t ev [DEPTH];
  slot_t od [DEPTH];
  logic  ev_err, od_err, waw;
  wb_shift_lane u_even (
    .clk(clk), .reset(reset), .result_i(bus.even_result), .addr_i(bus.even_addr),
    .write_i(bus.even_write), .lat_i(bus.even_lat), .flush_mask_i(bus.flush_mask),
    .flush_ins_i(bus.flush_ins), .slot_o(ev), .err_o(ev_err)
  );
  wb_shift_lane u_odd (
    .clk(clk), .reset(reset), .result_i(bus.odd_result), .addr_i(bus.odd_addr),
    .write_i(bus.odd_write), .lat_i(bus.odd_lat), .flush_mask_i(bus.flush_mask),
    .flush_ins_i(bus.flush_ins), .slot_o(od), .err_o(od_err)
  );
  for (genvar k = 0; k < DEPTH; k++) begin : g_fw
    assign bus.fw_even_wb[k] = ev[k].data;
    assign bus.fw_odd_wb[k] = od[k].data;
    assign bus.fw_addr_even_wb[k] = ev[k].addr;
    assign bus.fw_addr_odd_wb[k] = od[k].addr;
    assign bus.fw_write_even_wb[k] = ev[k].write;
    assign bus.fw_write_odd_wb[k] = od[k].write;
  end
  // even wins a same-address retirement; only the odd write port is suppressed
  assign waw = ev[DEPTH-1].write & od[DEPTH-1].write & (ev[DEPTH-1].addr == od[DEPTH-1].addr);
  assign bus.rf_even_data = ev[DEPTH-1].data;
  assign bus.rf_odd_data = od[DEPTH-1].data;
  assign bus.rf_even_addr = ev[DEPTH-1].addr;
  assign bus.rf_odd_addr = od[DEPTH-1].addr;
  assign bus.rf_even_we = ev[DEPTH-1].write;
  assign bus.rf_odd_we = od[DEPTH-1].write & ~waw;
  assign bus.waw_conflict = waw;
  assign bus.collision_err = ev_err | od_err;
endmodule

// File: tb/tb_wb_forward_pipe.sv
// tb_wb_forward_pipe: table-driven per-cycle vectors plus directed data/flush/timing sequences
module tb_wb_forward_pipe;
  logic clk = 1'b0;
  logic reset;
  int nvec = 0;
  int nerr = 0;
  wb_forward_pipe_if bus ();
  wb_forward_pipe dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic rst;
    logic ew; logic [6:0] ea; logic [2:0] el;
    logic ow; logic [6:0] oa; logic [2:0] ol;
    logic [6:0] fm; logic fi;
    logic [6:0] few, fow;
    logic rew; logic [6:0] rea;
    logic row; logic [6:0] roa;
    logic waw, err;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic rst, logic ew, logic [6:0] ea, logic [2:0] el,
                              logic ow, logic [6:0] oa, logic [2:0] ol, logic [6:0] fm, logic fi,
                              logic [6:0] few, logic [6:0] fow, logic rew, logic [6:0] rea,
                              logic row, logic [6:0] roa, logic waw, logic err);
    vec_t v;
    v = '{rst, ew, ea, el, ow, oa, ol, fm, fi, few, fow, rew, rea, row, roa, waw, err};
    return v;
  endfunction
  function automatic logic [127:0] edat(logic [6:0] a);
    return {16{1'b1, a}};
  endfunction
  function automatic logic [127:0] odat(logic [6:0] a);
    return {16{a, 1'b1}};
  endfunction
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic idle();
    bus.even_write = 0; bus.even_addr = '0; bus.even_lat = '0; bus.even_result = '0;
    bus.odd_write = 0; bus.odd_addr = '0; bus.odd_lat = '0; bus.odd_result = '0;
    bus.flush_mask = '0; bus.flush_ins = 0;
  endtask
  initial begin
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 7'h00,7'h00, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0, 1,5,2, 1,9,7, 0,0, 7'h02,7'h40, 0,0, 1,9, 0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 7'h04,7'h00, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 7'h08,7'h00, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 7'h10,7'h00, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 7'h20,7'h00, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 7'h40,7'h00, 1,5, 0,0, 0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 7'h00,7'h00, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0, 1,3,4, 0,0,0, 0,0, 7'h08,7'h00, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0, 0,0,0, 1,7,5, 7'h08,0, 7'h00,7'h10, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 7'h00,7'h20, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 7'h00,7'h40, 0,0, 1,7, 0,0));
    tbl.push_back(mk(0, 1,2,3, 1,2,3, 0,1, 7'h00,7'h00, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0, 1,12,6, 1,12,6, 0,0, 7'h20,7'h20, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 7'h40,7'h40, 1,12, 0,12, 1,0));
    tbl.push_back(mk(0, 1,4,7, 1,8,7, 0,0, 7'h40,7'h40, 1,4, 1,8, 0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 7'h00,7'h00, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0, 1,1,1, 0,0,0, 0,0, 7'h01,7'h00, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0, 1,2,2, 0,0,0, 0,0, 7'h02,7'h00, 0,0, 0,0, 0,1));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 7'h04,7'h00, 0,0, 0,0, 0,1));
    tbl.push_back(mk(0, 1,6,1, 1,10,3, 0,0, 7'h09,7'h04, 0,0, 0,0, 0,1));
    tbl.push_back(mk(0, 0,0,0, 1,11,1, 0,0, 7'h12,7'h09, 0,0, 0,0, 0,1));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 7'h00,7'h00, 0,0, 0,0, 0,0));
    tbl.push_back(mk(0, 1,7,0, 0,0,0, 0,0, 7'h00,7'h00, 0,0, 0,0, 0,1));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 7'h00,7'h00, 0,0, 0,0, 0,1));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 7'h00,7'h00, 0,0, 0,0, 0,0));
    reset = 1'b1;
    idle();
    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst;
      bus.even_write = tbl[i].ew; bus.even_addr = tbl[i].ea; bus.even_lat = tbl[i].el;
      bus.even_result = edat(tbl[i].ea);
      bus.odd_write = tbl[i].ow; bus.odd_addr = tbl[i].oa; bus.odd_lat = tbl[i].ol;
      bus.odd_result = odat(tbl[i].oa);
      bus.flush_mask = tbl[i].fm; bus.flush_ins = tbl[i].fi;
      @(posedge clk);
      #1;
      nvec++;
      chk($sformatf("row%0d fw_write_even", i), 128'(bus.fw_write_even_wb), 128'(tbl[i].few));
      chk($sformatf("row%0d fw_write_odd", i), 128'(bus.fw_write_odd_wb), 128'(tbl[i].fow));
      chk($sformatf("row%0d rf_even_we", i), 128'(bus.rf_even_we), 128'(tbl[i].rew));
      chk($sformatf("row%0d rf_odd_we", i), 128'(bus.rf_odd_we), 128'(tbl[i].row));
      chk($sformatf("row%0d waw_conflict", i), 128'(bus.waw_conflict), 128'(tbl[i].waw));
      chk($sformatf("row%0d collision_err", i), 128'(bus.collision_err), 128'(tbl[i].err));
      if (tbl[i].rew) begin
        chk($sformatf("row%0d rf_even_addr", i), 128'(bus.rf_even_addr), 128'(tbl[i].rea));
        chk($sformatf("row%0d rf_even_data", i), bus.rf_even_data, edat(tbl[i].rea));
      end
      if (tbl[i].row) begin
        chk($sformatf("row%0d rf_odd_addr", i), 128'(bus.rf_odd_addr), 128'(tbl[i].roa));
        chk($sformatf("row%0d rf_odd_data", i), bus.rf_odd_data, odat(tbl[i].roa));
      end
    end
    // latency-7 insert retires immediately with full data on both ports
    @(negedge clk);
    reset = 1'b0;
    idle();
    bus.even_write = 1; bus.even_addr = 7'd5; bus.even_lat = 3'd7;
    bus.even_result = {32{4'hA}};
    bus.odd_write = 1; bus.odd_addr = 7'd9; bus.odd_lat = 3'd7;
    bus.odd_result = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    @(posedge clk);
    #1;
    nvec++;
    chk("l7 rf_even_data", bus.rf_even_data, {32{4'hA}});
    chk("l7 rf_even_addr", 128'(bus.rf_even_addr), 128'd5);
    chk("l7 fw_even_wb6", bus.fw_even_wb[6], {32{4'hA}});
    chk("l7 fw_addr_even6", 128'(bus.fw_addr_even_wb[6]), 128'd5);
    chk("l7 rf_odd_data", bus.rf_odd_data, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
    chk("l7 rf_odd_we", 128'(bus.rf_odd_we), 128'd1);
    chk("l7 fw_addr_odd6", 128'(bus.fw_addr_odd_wb[6]), 128'd9);
    // flushed entry keeps data/addr but never retires
    @(negedge clk);
    idle();
    bus.even_write = 1; bus.even_addr = 7'd33; bus.even_lat = 3'd1;
    bus.even_result = {4{32'hDEADBEEF}};
    @(posedge clk);
    #1;
    nvec++;
    chk("fl slot0 write", 128'(bus.fw_write_even_wb[0]), 128'd1);
    @(negedge clk);
    idle();
    bus.flush_mask = 7'b0000001;
    @(posedge clk);
    #1;
    nvec++;
    chk("fl slot1 write", 128'(bus.fw_write_even_wb[1]), 128'd0);
    chk("fl slot1 data", bus.fw_even_wb[1], {4{32'hDEADBEEF}});
    chk("fl slot1 addr", 128'(bus.fw_addr_even_wb[1]), 128'd33);
    @(negedge clk);
    idle();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      nvec++;
      chk($sformatf("fl retire c%0d", c), 128'(bus.rf_even_we), 128'd0);
    end
    // forwarding taps must not see an insertion before the edge
    @(negedge clk);
    bus.even_write = 1; bus.even_addr = 7'd2; bus.even_lat = 3'd1;
    bus.even_result = edat(7'd2);
    #1;
    nvec++;
    chk("pre-edge fw_write_even", 128'(bus.fw_write_even_wb), 128'd0);
    @(posedge clk);
    #1;
    nvec++;
    chk("post-edge fw_write_even", 128'(bus.fw_write_even_wb), 128'h01);
    chk("post-edge collision_err", 128'(bus.collision_err), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/wb_forward_pipe.md
# wb_forward_pipe

Result shift-register stage for the even and odd SPU execution pipes. It sits between the execution units and the register file. Each unit's result is inserted at the depth that matches the unit's latency. Every slot is exposed to the operand forwarding unit through the `fw_*_wb` buses, and slot 6 of each pipe is retired to the two register-file write ports. It also handles branch flush masking and even/odd write-after-write (WAW) conflicts at retirement.

## Interface
- `DEPTH`, 7: slots per pipe; fixed to match the 7-entry forwarding buses.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `even_result` in [0:127]: even-pipe result.
- `even_addr` in [0:6]: destination register of the even result.
- `even_write` in 1: even result is valid and writes the register file.
- `even_lat` in [2:0]: even unit latency, legal range 1..7.
- `odd_result`, `odd_addr`, `odd_write`, `odd_lat`: same fields for the odd pipe.
- `flush_mask` in [6:0]: bit k clears the write flag of slot k in both pipes.
- `flush_ins` in 1: suppresses this cycle's even and odd insertions.
- `fw_even_wb`, `fw_odd_wb` out [6:0][0:127]: slot data.
- `fw_addr_even_wb`, `fw_addr_odd_wb` out [6:0][0:6]: slot destinations.
- `fw_write_even_wb`, `fw_write_odd_wb` out [6:0]: slot write flags.
- `rf_even_data`, `rf_odd_data` out [0:127]: register-file write data.
- `rf_even_addr`, `rf_odd_addr` out [0:6]: register-file write addresses.
- `rf_even_we`, `rf_odd_we` out 1: register-file write enables.
- `collision_err` out 1: sticky; set when an insertion overwrites a live slot or `*_lat` is illegal.
- `waw_conflict` out 1: one-cycle pulse on an even/odd same-address retirement.

## Operation
- Each pipe is a register array of 7 slots holding {data, addr, write}.
- Every cycle, each slot shifts: slot[k] ← slot[k-1] for k = 1..6, and slot[0] ← empty (write = 0).
- Flush is applied to the shifted value: the new slot[k] has write = old slot[k-1].write & ~flush_mask[k-1].
  - Flushed entries keep their data and addr but never forward or retire.
- Insertion, per pipe: if `*_write` = 1, `flush_ins` = 0 and `*_lat` is in 1..7, slot[lat-1] ← {result, addr, 1}. This overrides the shift into that slot.
- Collision: if the shifted-in value for slot[lat-1] has write = 1 after masking, the insertion still wins and `collision_err` sets.
- `*_lat` = 0 with `*_write` = 1: the insertion is dropped and `collision_err` sets.
- `collision_err` clears only on `reset`.
- Retirement is combinational from slot 6: `rf_*_data/addr` = slot 6 data/addr, and `rf_*_we` = slot 6 write.
- WAW: if both slot-6 entries have write = 1 and equal addr, the even pipe wins. In that case `rf_odd_we` = 0 and `waw_conflict` pulses in the same cycle.
  - The `fw_write_odd_wb[6]` output is unaffected.
- Reset: all data, addr and write bits are 0, so every output is 0. `collision_err` and `waw_conflict` are 0.

## Timing
- An insertion sampled at edge t with latency L is visible at index L-1 after edge t.
- It then advances one index per edge and sits at index 6 during the cycle after edge t + (7 - L).
- It retires on the register-file write port that cycle.
- The entry is visible to forwarding for 8 - L cycles in total.
- The `fw_*` outputs are direct register outputs, with no combinational path from inputs.
- The `rf_*` outputs and `waw_conflict` are combinational from slot 6 only.
- Reset asserted mid-flight discards all in-flight entries on that edge; there are no retirements on the following cycle.
- Simultaneous even and odd insertions are independent; the same latency in both pipes is legal.
- A flush and an insertion in the same cycle: `flush_mask` acts only on shifted entries. The insertion is governed solely by `flush_ins`.

## Structure
- A shared package holds:
  - `typedef` for the slot struct {data[0:127], addr[0:6], write}
  - `DEPTH`
  - `LAT_MIN` = 1
  - `LAT_MAX` = 7
- Sub-module `wb_shift_lane`: one pipe's shift, flush, insertion and collision detection. It is instantiated twice (even, odd).
- The top level adds the WAW arbitration and ORs the two lanes' error flags.

## Test plan
- Even insert: addr 5, data 0xA…A, L = 2 at cycle 0. The entry appears at index 1 in cycle 1 and retires in cycle 6 with `rf_even_we` = 1 and addr 5. `collision_err` stays 0.
- Odd L = 7, addr 9: the entry appears at index 6 in cycle 1 and retires in cycle 1 only.
- Collision: even L = 1 at cycle 0, then L = 2 at cycle 1, both writing. Slot 1 holds the second entry after edge 1 and `collision_err` = 1 from that cycle.
- Flush: an entry at index 3 with `flush_mask` = 7'b0001000. At index 4 on the next cycle it has write = 0, and `rf_even_we` is never asserted for it.
- WAW: even and odd entries both with addr 12 reach index 6 together. `rf_even_we` = 1, `rf_odd_we` = 0 and `waw_conflict` = 1 for one cycle.
- Reset mid-flight with 4 live entries: after the edge, all `fw_write_*` = 0, `rf_*_we` = 0 and `collision_err` = 0.
